// File: rtl/syscall_unit_pkg.sv
// Shared constants for the SYSCALL console unit.
// Holds the MIPS service codes, the ASCII characters used when formatting
// output, the FSM state encoding and a nibble-to-ASCII helper.
package syscall_unit_pkg;

  localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SVC_PRINT_HEX  = 32'd34;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h61;
  localparam logic [7:0] ASCII_MINUS = 8'h2d;
  localparam logic [7:0] ASCII_X     = 8'h78;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_EMIT,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    MODE_CHAR,
    MODE_HEX,
    MODE_DEC
  } mode_t;

  // Lowercase hex character for a nibble; also serves decimal digits 0-9.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'h0, n};
    else           return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/syscall_div10.sv
// Serial restoring divide-by-10, one quotient bit per cycle (32 cycles).
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, dividend   load a new 32-bit dividend (accepted when not busy)
//   busy              division in progress
//   done              one-cycle pulse: quotient/remainder are valid
//   quotient          32-bit quotient
//   remainder         4-bit remainder (0..9)
module syscall_div10 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [3:0]  remainder
);

  logic [31:0] q;
  logic [3:0]  r;
  logic [4:0]  cnt;
  logic        busy_r;
  logic        done_r;

  // Partial remainder never exceeds 19, so 5 bits suffice for the trial.
  logic [4:0] trial;
  logic [4:0] diff;
  logic       ge;

  always_comb begin
    trial = {r, q[31]};
    diff  = trial - 5'd10;
    ge    = (trial >= 5'd10);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (busy_r) begin
        q   <= {q[30:0], ge};
        r   <= ge ? diff[3:0] : trial[3:0];
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end else if (start) begin
        q      <= dividend;
        r      <= '0;
        cnt    <= '0;
        busy_r <= 1'b1;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = q;
  assign remainder = r;

endmodule

// File: rtl/syscall_unit.sv
// SYSCALL console unit: services print-int (1), print-char (11),
// print-hex (34) and exit (10) by streaming ASCII bytes over a
// valid/ready interface while stalling the pipeline.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   syscall                SYSCALL decoded this cycle
//   registerv0, registera0 service code and argument
//   out_ready              console sink accepts out_data
//   out_valid, out_data    offered ASCII byte
//   stall                  freeze PC and register-file writes
//   halted                 exit executed; only reset leaves this state
module syscall_unit
  import syscall_unit_pkg::*;
#(
  parameter int unsigned DIGITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  input  logic [31:0] registerv0,
  input  logic [31:0] registera0,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        stall,
  output logic        halted
);

  localparam int unsigned SPW = $clog2(DIGITS + 1);

  state_t state, state_next;
  mode_t  mode;

  logic [31:0]    a0_reg;
  logic           neg;
  logic [3:0]     idx;
  logic [3:0]     stack [DIGITS];
  logic [SPW-1:0] sp;
  logic [7:0]     data_r;

  logic        div_start, div_busy, div_done;
  logic [31:0] div_in, div_q;
  logic [3:0]  div_r;

  logic        capture, conv_step, conv_last, emit_adv, last_byte, is_svc;
  logic [31:0] magnitude;
  logic [3:0]  next_idx;
  logic [2:0]  rshift;
  logic [7:0]  hex_next;

  syscall_div10 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_in),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    is_svc    = (registerv0 == SVC_PRINT_INT) || (registerv0 == SVC_PRINT_CHAR) ||
                (registerv0 == SVC_PRINT_HEX) || (registerv0 == SVC_EXIT);
    // Two's-complement negate; 0x80000000 maps onto itself as unsigned.
    magnitude = registera0[31] ? (~registera0 + 32'd1) : registera0;
    // Hex byte k (k>=2) is nibble 9-k counted from the LSB.
    next_idx  = idx + 4'd1;
    rshift    = 3'(4'd9 - next_idx);
    hex_next  = (next_idx == 4'd1) ? ASCII_X : hex_ascii(a0_reg[{rshift, 2'b00} +: 4]);
    unique case (mode)
      MODE_CHAR: last_byte = 1'b1;
      MODE_HEX:  last_byte = (idx == 4'd9);
      default:   last_byte = (sp == '0);
    endcase
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    div_start  = 1'b0;
    div_in     = div_q;
    conv_step  = 1'b0;
    conv_last  = 1'b0;
    emit_adv   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (syscall) begin
          if (registerv0 == SVC_PRINT_INT) begin
            capture    = 1'b1;
            div_start  = 1'b1;
            div_in     = magnitude;
            state_next = ST_CONV;
          end else if (registerv0 == SVC_PRINT_CHAR || registerv0 == SVC_PRINT_HEX) begin
            capture    = 1'b1;
            state_next = ST_EMIT;
          end else if (registerv0 == SVC_EXIT) begin
            state_next = ST_HALT;
          end
        end
      end
      ST_CONV: begin
        if (div_done && !div_busy) begin
          if (div_q == '0) begin
            conv_last  = 1'b1;
            state_next = ST_EMIT;
          end else begin
            conv_step = 1'b1;
            div_start = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (last_byte) state_next = ST_IDLE;
          else           emit_adv   = 1'b1;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode   <= MODE_CHAR;
      a0_reg <= '0;
      neg    <= 1'b0;
      idx    <= '0;
      sp     <= '0;
      data_r <= '0;
      for (int unsigned i = 0; i < DIGITS; i++) stack[i] <= '0;
    end else begin
      if (capture) begin
        a0_reg <= registera0;
        neg    <= registera0[31];
        idx    <= '0;
        sp     <= '0;
        if (registerv0 == SVC_PRINT_INT) begin
          mode <= MODE_DEC;
        end else if (registerv0 == SVC_PRINT_HEX) begin
          mode   <= MODE_HEX;
          data_r <= ASCII_0;
        end else begin
          mode   <= MODE_CHAR;
          data_r <= registera0[7:0];
        end
      end
      // The final remainder is the most significant digit: when there is no
      // sign to print it goes straight to out_data instead of the stack.
      if (conv_step || (conv_last && neg)) begin
        stack[sp] <= div_r;
        sp        <= sp + 1'b1;
      end
      if (conv_last) data_r <= neg ? ASCII_MINUS : hex_ascii(div_r);
      if (emit_adv) begin
        if (mode == MODE_HEX) begin
          idx    <= next_idx;
          data_r <= hex_next;
        end else begin
          data_r <= hex_ascii(stack[sp - 1'b1]);
          sp     <= sp - 1'b1;
        end
      end
    end
  end

  assign out_valid = (state == ST_EMIT);
  assign halted    = (state == ST_HALT);
  assign out_data  = data_r;
  assign stall     = (state != ST_IDLE) || (syscall && is_svc);

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        syscall = 1'b0;
  logic [31:0] registerv0 = '0;
  logic [31:0] registera0 = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        stall;
  logic        halted;

  syscall_unit #(.DIGITS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .syscall    (syscall),
    .registerv0 (registerv0),
    .registera0 (registera0),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .stall      (stall),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int xfer_call = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 hold low 3 cycles at byte 4
  int hold_left = 0;
  bit hold_done = 0;
  bit mon_hold = 0;
  logic [7:0] mon_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: format the service output directly from its meaning.
  task automatic push_model(input logic [31:0] v0, input logic [31:0] a0);
    string s;
    logic [7:0] ch;
    case (v0)
      32'd1:  s = $sformatf("%0d", $signed(a0));
      32'd34: s = $sformatf("0x%08h", a0);
      32'd11: begin ch = a0[7:0]; exp_q.push_back(ch); return; end
      default: return;
    endcase
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Monitor / scoreboard: handshake is sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_hold = 0;
      end else begin
        if (mon_hold) begin
          check("hold_valid", {31'b0, out_valid}, 32'd1);
          check("hold_data", {24'b0, out_data}, {24'b0, mon_data});
        end
        if (out_valid && out_ready) begin
          xfer_call++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", out_data);
          end else begin
            check("byte", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
          end
        end
        mon_hold = out_valid && !out_ready;
        mon_data = out_data;
      end
    end
  end

  // Sink ready generator.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (xfer_call == 3 && !hold_done) begin
            hold_left = 3;
            hold_done = 1;
          end
          if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Issue one syscall (called at posedge+1 with the unit idle) and wait for
  // it to finish, scrambling the inputs while it is busy.
  task automatic run_call(input logic [31:0] v0, input logic [31:0] a0, input int mode,
                          output int sc);
    bit fin;
    bit exp_st;
    ready_mode = mode;
    xfer_call  = 0;
    hold_done  = 0;
    hold_left  = 0;
    push_model(v0, a0);
    registerv0 = v0;
    registera0 = a0;
    syscall    = 1'b1;
    exp_st = (v0 == 1) || (v0 == 10) || (v0 == 11) || (v0 == 34);
    @(negedge clk);
    check("stall_capture", {31'b0, stall}, {31'b0, exp_st});
    sc = stall ? 1 : 0;
    @(posedge clk); #1;
    if (v0 == 10) begin
      syscall = 1'b0;
      return;
    end
    fin = 0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      if (exp_q.size() == 0) begin
        syscall = 1'b0;
      end else begin
        syscall    = 1'($urandom_range(0, 1));
        registerv0 = $urandom_range(0, 40);
        registera0 = $urandom;
      end
      @(negedge clk);
      if (!stall) fin = 1;
      else begin
        sc++;
        @(posedge clk); #1;
      end
    end
    if (!fin) begin
      n_total++;
      $display("FAIL timeout: stall still high for v0=%0d a0=0x%0h", v0, a0);
    end
    check("queue_drained", exp_q.size(), 32'd0);
    syscall = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int sc;
    int v;
    logic [31:0] a;
    logic [31:0] specials [7];
    int noops [8];
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd9, 32'd10};
    noops    = '{0, 2, 4, 5, 12, 33, 35, 100};

    // Reset values.
    #3;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data", {24'b0, out_data}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Single character, always-ready sink: stall spans capture + one EMIT cycle.
    run_call(32'd11, 32'h0000_0141, 0, sc);
    check("char_stall_cycles", sc, 32'd2);
    check("char_idle_valid", {31'b0, out_valid}, 32'd0);

    // Hex print streams 10 bytes back to back.
    run_call(32'd34, 32'h0000_BEEF, 0, sc);
    check("hex_stall_cycles", sc, 32'd11);

    // Decimal corner values.
    run_call(32'd1, 32'hFFFF_FF85, 0, sc);
    run_call(32'd1, 32'h8000_0000, 0, sc);
    run_call(32'd1, 32'h0000_0000, 0, sc);
    run_call(32'd1, 32'd4294967295 >> 1, 1, sc);

    // Backpressure at byte 4.
    run_call(32'd34, 32'h1234_ABCD, 2, sc);
    check("hex_hold_stall_cycles", sc, 32'd14);

    // Randomized services.
    for (int k = 0; k < 40; k++) begin
      v = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 6)] : $urandom;
      case (v)
        0: run_call(32'd1, a, $urandom_range(0, 1), sc);
        1: run_call(32'd11, a, $urandom_range(0, 1), sc);
        2: run_call(32'd34, a, $urandom_range(0, 1), sc);
        default: begin
          run_call(noops[$urandom_range(0, 7)], a, 0, sc);
          check("noop_stall_cycles", sc, 32'd0);
        end
      endcase
    end

    // Reset during byte 3 of a hex print aborts it.
    ready_mode = 0;
    xfer_call  = 0;
    push_model(32'd34, 32'hCAFE_0001);
    registerv0 = 32'd34;
    registera0 = 32'hCAFE_0001;
    syscall    = 1'b1;
    @(posedge clk); #1;
    syscall = 1'b0;
    for (int i = 0; i < 50 && xfer_call < 2; i++) begin
      @(negedge clk); #2;
    end
    check("abort_reached_byte3", xfer_call, 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_valid", {31'b0, out_valid}, 32'd0);
    check("abort_data", {24'b0, out_data}, 32'd0);
    check("abort_stall", {31'b0, stall}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", {31'b0, out_valid}, 32'd0);
      check("post_rst_data", {24'b0, out_data}, 32'd0);
    end
    @(posedge clk); #1;
    run_call(32'd11, 32'h0000_005A, 0, sc);
    check("after_abort_char_stall", sc, 32'd2);

    // Exit, then ignored syscall, then reset releases halt.
    run_call(32'd10, 32'h0, 0, sc);
    @(negedge clk);
    check("exit_halted", {31'b0, halted}, 32'd1);
    check("exit_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    registerv0 = 32'd11;
    registera0 = 32'h0000_0041;
    syscall    = 1'b1;
    @(posedge clk); #1;
    syscall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_no_valid", {31'b0, out_valid}, 32'd0);
      check("halt_kept", {31'b0, halted}, 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_clears_halted", {31'b0, halted}, 32'd0);
    check("rst_clears_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_call(32'd1, 32'hFFFF_FF85, 1, sc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 The block SHALL have parameter DIGITS, default 10, giving the maximum number of decimal digits in the conversion buffer.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port syscall, input, 1 bit: the control unit has decoded a SYSCALL instruction this cycle.
REQ-005 The block SHALL have port registerv0, input, 32 bits: the current $v0 value, the service code.
REQ-006 The block SHALL have port registera0, input, 32 bits: the current $a0 value, the service argument.
REQ-007 The block SHALL have port out_ready, input, 1 bit: the console sink accepts out_data this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid ASCII byte.
REQ-009 The block SHALL have port out_data, output, 8 bits: the ASCII byte being offered.
REQ-010 The block SHALL have port stall, output, 1 bit: the PC and register-file writes are frozen.
REQ-011 The block SHALL have port halted, output, 1 bit: the program executed exit.

Function
REQ-012 Services SHALL be decoded from registerv0 as follows: 1 = print signed decimal; 11 = print char; 34 = print hex; 10 = exit; any other code = no-op.
REQ-013 In IDLE, with syscall=1 and halted=0, the block SHALL capture registerv0 and registera0 on that edge; later changes to the inputs SHALL be ignored until the block returns to IDLE.
REQ-014 stall SHALL be combinationally high in the capture cycle for services 1, 11, 34 and 10, stay high while state is not IDLE, and go low in the cycle after the last byte handshake; a no-op service SHALL never raise stall.
REQ-015 The FSM SHALL have the states IDLE, CONV, EMIT and HALT.
REQ-016 IDLE SHALL transition to CONV for service 1, to EMIT for services 11 and 34, and to HALT for service 10.
REQ-017 The char service (11) SHALL emit exactly one byte, registera0[7:0].
REQ-018 The hex service (34) SHALL emit 10 bytes: "0x" followed by 8 lowercase hex digits, most significant first, with leading zeros kept.
REQ-019 The decimal service (1) SHALL emit '-' first if registera0[31]=1, then the digits of the unsigned magnitude with no leading zeros; a value of 0 SHALL emit "0".
REQ-020 The magnitude of 0x80000000 SHALL be 2147483648, computed in 32-bit unsigned arithmetic without overflow.
REQ-021 CONV SHALL repeatedly divide the magnitude by 10 using a serial restoring divider, 32 cycles per digit, pushing each remainder onto a DIGITS-deep digit stack.
REQ-022 CONV SHALL move to EMIT when the quotient reaches 0.
REQ-023 EMIT SHALL pop digits from the stack so that the most significant digit is emitted first.
REQ-024 Handshake: a byte transfers on a rising edge where out_valid=1 and out_ready=1.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL be held stable and out_valid SHALL NOT drop.
REQ-026 out_valid SHALL be high only in EMIT; back-to-back bytes SHALL be possible on consecutive cycles.
REQ-027 EMIT SHALL return to IDLE on the handshake of the final byte.
REQ-028 HALT SHALL set halted=1 and hold stall=1 permanently; syscall SHALL be ignored in HALT, and only reset SHALL leave HALT.
REQ-029 syscall asserted while the state is not IDLE SHALL be ignored.

Reset
REQ-030 While rst=0, asynchronously: state=IDLE, out_valid=0, out_data=0, stall=0, halted=0, digit stack pointer=0, divider cleared.
REQ-031 Reset asserted mid-CONV or mid-EMIT SHALL abort the operation; out_valid SHALL drop without completing the byte.
REQ-032 After rst rises, no output SHALL change until the next syscall.

Structure
REQ-033 A shared package SHALL hold the service codes (1, 10, 11, 34), the ASCII constants ('0', 'a', '-', 'x'), and the FSM state encoding.
REQ-034 The serial divide-by-10 SHALL be a sub-module named syscall_div10 (start/busy/done, 32-bit quotient, 4-bit remainder).

Verification
REQ-035 A bench SHALL cover: v0=11, a0=0x00000141, out_ready=1 -> a single byte 0x41, stall high 2 cycles, then IDLE.
REQ-036 A bench SHALL cover: v0=34, a0=0x0000BEEF -> the bytes "0x0000beef", 10 transfers in 10 consecutive cycles.
REQ-037 A bench SHALL cover: v0=1, a0=0xFFFFFF85 (-123) -> "-123"; and v0=1, a0=0x80000000 -> "-2147483648"; and a0=0 -> "0".
REQ-038 A bench SHALL cover: v0=34 with out_ready held low for 3 cycles at byte 4 -> out_data stable, no byte lost or duplicated.
REQ-039 A bench SHALL cover: v0=10 -> halted=1 and stall=1 from the next cycle; a later syscall with v0=11 -> no output; rst low -> halted=0.
REQ-040 A bench SHALL cover: rst pulsed low during byte 3 of a hex print -> out_valid=0 immediately; a following v0=11 print works normally.
